// File: rtl/dm_hart_ctl_pkg.sv
// Shared types and constants for the debug-module hart controller.
package dm_hart_ctl_pkg;

    // Per-hart run state as seen by the debug module.
    typedef enum logic [1:0] {
        HART_RUNNING  = 2'd0,
        HART_HALTED   = 2'd1,
        HART_RESUMING = 2'd2
    } hart_state_e;

    // Abstract command dispatcher state.
    typedef enum logic {
        CMD_IDLE = 1'b0,
        CMD_EXEC = 1'b1
    } cmd_state_e;

    // Abstract command error codes.
    localparam logic [2:0] CMDERR_NONE       = 3'd0;
    localparam logic [2:0] CMDERR_BUSY       = 3'd1;
    localparam logic [2:0] CMDERR_EXCEPTION  = 3'd3;
    localparam logic [2:0] CMDERR_HALTRESUME = 3'd4;

    // Sticky W1C error register update: a new error code overrides the clear mask.
    function automatic logic [2:0] cmderr_next(
        input logic [2:0] cur,
        input logic       set,
        input logic [2:0] code,
        input logic [2:0] clr
    );
        logic [2:0] res;
        if (set) begin
            res = code;
        end else begin
            res = cur & ~clr;
        end
        return res;
    endfunction

endpackage

// File: rtl/dm_hart_slot.sv
// Per-hart bookkeeping: run state machine, halt request, resumeack and havereset.
module dm_hart_slot
    import dm_hart_ctl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic dmactive,
    input  logic sel,
    input  logic ctl_write,
    input  logic ctl_haltreq,
    input  logic ctl_resumereq,
    input  logic ctl_ackhavereset,
    input  logic hart_halted,
    input  logic hart_reset,
    output logic halt_req,
    output logic resume_req,
    output logic is_halted,
    output logic resumeack,
    output logic havereset
);

    hart_state_e state_r;
    hart_state_e state_s;
    logic        resume_acc_s;
    logic        halt_req_r;
    logic        resumeack_r;
    logic        havereset_r;

    // Resume is only taken from a halted, selected hart and loses against a halt request.
    always_comb begin
        resume_acc_s = ctl_write & ctl_resumereq & ~ctl_haltreq & sel
                     & (state_r == HART_HALTED);
    end

    // State register; dmactive low behaves exactly like reset.
    always_ff @(posedge clk) begin
        if (!rst_n || !dmactive) begin
            state_r <= HART_RUNNING;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a halted hart may drop straight to running when it is reset.
    always_comb begin
        state_s = state_r;
        case (state_r)
            HART_RUNNING: begin
                if (hart_halted) begin
                    state_s = HART_HALTED;
                end else begin
                    state_s = HART_RUNNING;
                end
            end
            HART_HALTED: begin
                if (resume_acc_s) begin
                    state_s = HART_RESUMING;
                end else if (!hart_halted) begin
                    state_s = HART_RUNNING;
                end else begin
                    state_s = HART_HALTED;
                end
            end
            HART_RESUMING: begin
                if (!hart_halted) begin
                    state_s = HART_RUNNING;
                end else begin
                    state_s = HART_RESUMING;
                end
            end
            default: begin
                state_s = HART_RUNNING;
            end
        endcase
    end

    // State-derived outputs.
    always_comb begin
        resume_req = (state_r == HART_RESUMING);
        is_halted  = (state_r == HART_HALTED);
    end

    // Halt request, resumeack and havereset flags; a reset pulse beats an acknowledge.
    always_ff @(posedge clk) begin
        if (!rst_n || !dmactive) begin
            halt_req_r  <= 1'b0;
            resumeack_r <= 1'b0;
            havereset_r <= 1'b1;
        end else begin
            if (ctl_write && sel) begin
                halt_req_r <= ctl_haltreq;
            end else begin
                halt_req_r <= halt_req_r;
            end

            if (resume_acc_s) begin
                resumeack_r <= 1'b0;
            end else if ((state_r == HART_RESUMING) && !hart_halted) begin
                resumeack_r <= 1'b1;
            end else begin
                resumeack_r <= resumeack_r;
            end

            if (hart_reset) begin
                havereset_r <= 1'b1;
            end else if (ctl_write && ctl_ackhavereset && sel) begin
                havereset_r <= 1'b0;
            end else begin
                havereset_r <= havereset_r;
            end
        end
    end

    assign halt_req  = halt_req_r;
    assign resumeack = resumeack_r;
    assign havereset = havereset_r;

endmodule

// File: rtl/dm_hart_ctl.sv
// Debug-module hart controller: hart selection, dmstatus summaries, haltsum0
// and single-outstanding abstract command dispatch.
module dm_hart_ctl
    import dm_hart_ctl_pkg::*;
#(
    parameter int NHARTS     = 4,
    parameter int HARTSELLEN = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dmactive,
    input  logic [HARTSELLEN-1:0] hartsel,
    input  logic                  hasel,
    input  logic [NHARTS-1:0]     hawindow,
    input  logic                  ctl_write,
    input  logic                  ctl_haltreq,
    input  logic                  ctl_resumereq,
    input  logic                  ctl_ackhavereset,
    input  logic [NHARTS-1:0]     hart_halted,
    input  logic [NHARTS-1:0]     hart_reset,
    output logic [NHARTS-1:0]     hart_halt_req,
    output logic [NHARTS-1:0]     hart_resume_req,
    input  logic                  cmd_exec,
    input  logic [2:0]            cmderr_clr,
    output logic [NHARTS-1:0]     hart_exec,
    input  logic [NHARTS-1:0]     hart_done,
    input  logic [NHARTS-1:0]     hart_exc,
    output logic                  cmd_busy,
    output logic [2:0]            cmderr,
    output logic                  anyhalted,
    output logic                  allhalted,
    output logic                  anyrunning,
    output logic                  allrunning,
    output logic                  anyresumeack,
    output logic                  allresumeack,
    output logic                  anyhavereset,
    output logic                  allhavereset,
    output logic                  anynonexistent,
    output logic                  allnonexistent,
    output logic [31:0]           haltsum0
);

    logic [NHARTS-1:0] hartsel_oh_s;
    logic [NHARTS-1:0] sel_s;
    logic              hartsel_exists_s;
    logic              sel_any_s;
    logic [NHARTS-1:0] halted_st_s;
    logic [NHARTS-1:0] resumeack_st_s;
    logic [NHARTS-1:0] havereset_st_s;

    cmd_state_e        cmd_state_r;
    cmd_state_e        cmd_state_s;
    logic [NHARTS-1:0] target_oh_r;
    logic [NHARTS-1:0] target_oh_s;
    logic              exec_pulse_r;
    logic              exec_pulse_s;
    logic [2:0]        cmderr_r;
    logic [2:0]        cmderr_s;
    logic              tgt_halted_s;
    logic              done_s;
    logic              exc_s;
    logic              err_set_s;
    logic [2:0]        err_code_s;

    // Decode hartsel to one-hot (all zero when out of range) and merge the hart window.
    always_comb begin
        hartsel_oh_s = {NHARTS{1'b0}};
        for (int i = 0; i < NHARTS; i++) begin
            hartsel_oh_s[i] = (int'(hartsel) == i) ? 1'b1 : 1'b0;
        end
        hartsel_exists_s = (int'(hartsel) < NHARTS);
        sel_s            = hartsel_oh_s | (hawindow & {NHARTS{hasel}});
        sel_any_s        = |sel_s;
    end

    for (genvar g = 0; g < NHARTS; g++) begin : g_slot
        dm_hart_slot u_slot (
            .clk              (clk),
            .rst_n            (rst_n),
            .dmactive         (dmactive),
            .sel              (sel_s[g]),
            .ctl_write        (ctl_write),
            .ctl_haltreq      (ctl_haltreq),
            .ctl_resumereq    (ctl_resumereq),
            .ctl_ackhavereset (ctl_ackhavereset),
            .hart_halted      (hart_halted[g]),
            .hart_reset       (hart_reset[g]),
            .halt_req         (hart_halt_req[g]),
            .resume_req       (hart_resume_req[g]),
            .is_halted        (halted_st_s[g]),
            .resumeack        (resumeack_st_s[g]),
            .havereset        (havereset_st_s[g])
        );
    end

    // dmstatus summaries over the selected set; an empty set reports nothing but
    // nonexistence, and "all" is masked by a non-empty set.
    always_comb begin
        anyhalted      = |(halted_st_s & sel_s);
        allhalted      = sel_any_s & (&(halted_st_s | ~sel_s));
        anyrunning     = |(~halted_st_s & sel_s);
        allrunning     = sel_any_s & (&(~halted_st_s | ~sel_s));
        anyresumeack   = |(resumeack_st_s & sel_s);
        allresumeack   = sel_any_s & (&(resumeack_st_s | ~sel_s));
        anyhavereset   = |(havereset_st_s & sel_s);
        allhavereset   = sel_any_s & (&(havereset_st_s | ~sel_s));
        anynonexistent = ~hartsel_exists_s;
        allnonexistent = ~hartsel_exists_s & ~sel_any_s;
    end

    // haltsum0 mirrors the live halted levels, zero-filled above the last hart.
    always_comb begin
        haltsum0                 = 32'd0;
        haltsum0[NHARTS-1:0]     = hart_halted;
    end

    // Command qualifiers: the target must be halted at start; completion in the
    // exec-pulse cycle is too early to belong to this command.
    always_comb begin
        tgt_halted_s = |(hartsel_oh_s & halted_st_s);
        done_s       = (cmd_state_r == CMD_EXEC) & ~exec_pulse_r & (|(hart_done & target_oh_r));
        exc_s        = done_s & (|(hart_exc & target_oh_r));
    end

    // Abstract command state register, latched target and sticky error.
    always_ff @(posedge clk) begin
        if (!rst_n || !dmactive) begin
            cmd_state_r  <= CMD_IDLE;
            target_oh_r  <= {NHARTS{1'b0}};
            exec_pulse_r <= 1'b0;
            cmderr_r     <= CMDERR_NONE;
        end else begin
            cmd_state_r  <= cmd_state_s;
            target_oh_r  <= target_oh_s;
            exec_pulse_r <= exec_pulse_s;
            cmderr_r     <= cmderr_s;
        end
    end

    // Abstract command next state; only the first error is recorded.
    always_comb begin
        cmd_state_s  = cmd_state_r;
        target_oh_s  = target_oh_r;
        exec_pulse_s = 1'b0;
        err_set_s    = 1'b0;
        err_code_s   = CMDERR_NONE;
        case (cmd_state_r)
            CMD_IDLE: begin
                if (cmd_exec && (cmderr_r == CMDERR_NONE)) begin
                    if (tgt_halted_s) begin
                        cmd_state_s  = CMD_EXEC;
                        target_oh_s  = hartsel_oh_s;
                        exec_pulse_s = 1'b1;
                    end else begin
                        err_set_s  = 1'b1;
                        err_code_s = CMDERR_HALTRESUME;
                    end
                end else begin
                    cmd_state_s = CMD_IDLE;
                end
            end
            CMD_EXEC: begin
                if (cmd_exec && (cmderr_r == CMDERR_NONE)) begin
                    err_set_s  = 1'b1;
                    err_code_s = CMDERR_BUSY;
                end else if (exc_s && (cmderr_r == CMDERR_NONE)) begin
                    err_set_s  = 1'b1;
                    err_code_s = CMDERR_EXCEPTION;
                end else begin
                    err_set_s = 1'b0;
                end
                if (done_s) begin
                    cmd_state_s = CMD_IDLE;
                end else begin
                    cmd_state_s = CMD_EXEC;
                end
            end
            default: begin
                cmd_state_s = CMD_IDLE;
            end
        endcase
        cmderr_s = cmderr_next(cmderr_r, err_set_s, err_code_s, cmderr_clr);
    end

    // Command outputs driven from registered state only.
    always_comb begin
        cmd_busy = (cmd_state_r == CMD_EXEC);
        cmderr   = cmderr_r;
        if (exec_pulse_r) begin
            hart_exec = target_oh_r;
        end else begin
            hart_exec = {NHARTS{1'b0}};
        end
    end

endmodule

// File: tb/tb_dm_hart_ctl.sv
// Directed, table-driven bench for dm_hart_ctl with NHARTS=4.
module tb_dm_hart_ctl;

    logic        clk;
    logic        rst_n;
    logic        dmactive;
    logic [4:0]  hartsel;
    logic        hasel;
    logic [3:0]  hawindow;
    logic        ctl_write;
    logic        ctl_haltreq;
    logic        ctl_resumereq;
    logic        ctl_ackhavereset;
    logic [3:0]  hart_halted;
    logic [3:0]  hart_reset;
    logic [3:0]  hart_halt_req;
    logic [3:0]  hart_resume_req;
    logic        cmd_exec;
    logic [2:0]  cmderr_clr;
    logic [3:0]  hart_exec;
    logic [3:0]  hart_done;
    logic [3:0]  hart_exc;
    logic        cmd_busy;
    logic [2:0]  cmderr;
    logic        anyhalted, allhalted, anyrunning, allrunning;
    logic        anyresumeack, allresumeack, anyhavereset, allhavereset;
    logic        anynonexistent, allnonexistent;
    logic [31:0] haltsum0;
    logic [9:0]  summ;

    int n_checks = 0;
    int n_fail   = 0;

    dm_hart_ctl #(.NHARTS(4), .HARTSELLEN(5)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .dmactive         (dmactive),
        .hartsel          (hartsel),
        .hasel            (hasel),
        .hawindow         (hawindow),
        .ctl_write        (ctl_write),
        .ctl_haltreq      (ctl_haltreq),
        .ctl_resumereq    (ctl_resumereq),
        .ctl_ackhavereset (ctl_ackhavereset),
        .hart_halted      (hart_halted),
        .hart_reset       (hart_reset),
        .hart_halt_req    (hart_halt_req),
        .hart_resume_req  (hart_resume_req),
        .cmd_exec         (cmd_exec),
        .cmderr_clr       (cmderr_clr),
        .hart_exec        (hart_exec),
        .hart_done        (hart_done),
        .hart_exc         (hart_exc),
        .cmd_busy         (cmd_busy),
        .cmderr           (cmderr),
        .anyhalted        (anyhalted),
        .allhalted        (allhalted),
        .anyrunning       (anyrunning),
        .allrunning       (allrunning),
        .anyresumeack     (anyresumeack),
        .allresumeack     (allresumeack),
        .anyhavereset     (anyhavereset),
        .allhavereset     (allhavereset),
        .anynonexistent   (anynonexistent),
        .allnonexistent   (allnonexistent),
        .haltsum0         (haltsum0)
    );

    // Summary bit order: anyhalted .. allnonexistent, MSB first.
    assign summ = {anyhalted, allhalted, anyrunning, allrunning, anyresumeack,
                   allresumeack, anyhavereset, allhavereset, anynonexistent, allnonexistent};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        hasel;
        logic [3:0]  hawindow;
        logic [4:0]  hartsel;
        logic [3:0]  ctl;      // {write, haltreq, resumereq, ackhavereset}
        logic [3:0]  halted;
        logic [3:0]  hreset;
        logic [3:0]  done;
        logic [3:0]  exc;
        logic        cexec;
        logic [2:0]  clr;
        logic [3:0]  e_hreq;
        logic [3:0]  e_rreq;
        logic [3:0]  e_exec;
        logic        e_busy;
        logic [2:0]  e_err;
        logic [9:0]  e_sum;
        logic [31:0] e_hs;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ctl_write        = 1'b0;
        ctl_haltreq      = 1'b0;
        ctl_resumereq    = 1'b0;
        ctl_ackhavereset = 1'b0;
        hart_reset       = 4'b0000;
        cmd_exec         = 1'b0;
        cmderr_clr       = 3'b000;
        hart_done        = 4'b0000;
        hart_exc         = 4'b0000;
    endtask

    initial begin
        //            hasel window  hsel  ctl      halted   hreset   done     exc     cexec clr     hreq     rreq     exec    busy err   sum             haltsum
        vecs[0]  = '{1'b0, 4'b0000, 5'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'b000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'd0, 10'b0011001100, 32'h0};
        vecs[1]  = '{1'b0, 4'b0000, 5'd0, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'b000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'd0, 10'b0011001100, 32'h0};
        vecs[2]  = '{1'b0, 4'b0000, 5'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'b000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'd0, 10'b0011000000, 32'h0};
        vecs[3]  = '{1'b1, 4'b0110, 5'd0, 4'b1100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'b000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'd0, 10'b0011001000, 32'h0};
        vecs[4]  = '{1'b1, 4'b0110, 5'd0, 4'b0000, 4'b0110, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'b000, 4'b0111, 4'b0000, 4'b0000, 1'b0, 3'd0, 10'b0011001000, 32'h6};
        vecs[5]  = '{1'b1, 4'b0110, 5'd0, 4'b0000, 4'b0110, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'b000, 4'b0111, 4'b0000, 4'b0000, 1'b0, 3'd0, 10'b1010001000, 32'h6};
        vecs[6]  = '{1'b0, 4'b0000, 5'd2, 4'b1010, 4'b0110, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'b000, 4'b0111, 4'b0000, 4'b0000, 1'b0, 3'd0, 10'b1100001100, 32'h6};
        vecs[7]  = '{1'b0, 4'b0000, 5'd2, 4'b0000, 4'b0110, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'b000, 4'b0011, 4'b0100, 4'b0000, 1'b0, 3'd0, 10'b0011001100, 32'h6};
        vecs[8]  = '{1'b0, 4'b0000, 5'd2, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'b000, 4'b0011, 4'b0100, 4'b0000, 1'b0, 3'd0, 10'b0011001100, 32'h2};
        vecs[9]  = '{1'b0, 4'b0000, 5'd2, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'b000, 4'b0011, 4'b0000, 4'b0000, 1'b0, 3'd0, 10'b0011111100, 32'h2};
        vecs[10] = '{1'b0, 4'b0000, 5'd7, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b1, 3'b000, 4'b0011, 4'b0000, 4'b0000, 1'b0, 3'd0, 10'b0000000011, 32'h2};
        vecs[11] = '{1'b0, 4'b0000, 5'd7, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'b000, 4'b0011, 4'b0000, 4'b0000, 1'b0, 3'd4, 10'b0000000011, 32'h2};
        vecs[12] = '{1'b0, 4'b0000, 5'd7, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'b100, 4'b0011, 4'b0000, 4'b0000, 1'b0, 3'd4, 10'b0000000011, 32'h2};
        vecs[13] = '{1'b0, 4'b0000, 5'd7, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'b000, 4'b0011, 4'b0000, 4'b0000, 1'b0, 3'd0, 10'b0000000011, 32'h2};
        vecs[14] = '{1'b0, 4'b0000, 5'd1, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b1, 3'b000, 4'b0011, 4'b0000, 4'b0000, 1'b0, 3'd0, 10'b1100001100, 32'h2};
        vecs[15] = '{1'b0, 4'b0000, 5'd1, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 1'b0, 3'b000, 4'b0011, 4'b0000, 4'b0010, 1'b1, 3'd0, 10'b1100001100, 32'h2};
        vecs[16] = '{1'b0, 4'b0000, 5'd3, 4'b0000, 4'b0010, 4'b0000, 4'b1000, 4'b0000, 1'b1, 3'b000, 4'b0011, 4'b0000, 4'b0000, 1'b1, 3'd0, 10'b0011001100, 32'h2};
        vecs[17] = '{1'b0, 4'b0000, 5'd3, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 1'b0, 3'b000, 4'b0011, 4'b0000, 4'b0000, 1'b1, 3'd1, 10'b0011001100, 32'h2};
        vecs[18] = '{1'b0, 4'b0000, 5'd3, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'b000, 4'b0011, 4'b0000, 4'b0000, 1'b0, 3'd1, 10'b0011001100, 32'h2};
        vecs[19] = '{1'b0, 4'b0000, 5'd1, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b1, 3'b001, 4'b0011, 4'b0000, 4'b0000, 1'b0, 3'd1, 10'b1100001100, 32'h2};
        vecs[20] = '{1'b0, 4'b0000, 5'd1, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'b000, 4'b0011, 4'b0000, 4'b0000, 1'b0, 3'd0, 10'b1100001100, 32'h2};
        vecs[21] = '{1'b1, 4'b0001, 5'd7, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'b000, 4'b0011, 4'b0000, 4'b0000, 1'b0, 3'd0, 10'b0011000010, 32'h2};

        rst_n       = 1'b0;
        dmactive    = 1'b1;
        hartsel     = 5'd0;
        hasel       = 1'b0;
        hawindow    = 4'b0000;
        hart_halted = 4'b0000;
        idle_inputs();
        repeat (2) @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            rst_n       = 1'b1;
            hasel       = vecs[i].hasel;
            hawindow    = vecs[i].hawindow;
            hartsel     = vecs[i].hartsel;
            {ctl_write, ctl_haltreq, ctl_resumereq, ctl_ackhavereset} = vecs[i].ctl;
            hart_halted = vecs[i].halted;
            hart_reset  = vecs[i].hreset;
            hart_done   = vecs[i].done;
            hart_exc    = vecs[i].exc;
            cmd_exec    = vecs[i].cexec;
            cmderr_clr  = vecs[i].clr;
            @(negedge clk);
            check($sformatf("r%0d_halt_req", i),   32'(hart_halt_req),   32'(vecs[i].e_hreq));
            check($sformatf("r%0d_resume_req", i), 32'(hart_resume_req), 32'(vecs[i].e_rreq));
            check($sformatf("r%0d_hart_exec", i),  32'(hart_exec),       32'(vecs[i].e_exec));
            check($sformatf("r%0d_busy_err", i),   32'({cmd_busy, cmderr}), 32'({vecs[i].e_busy, vecs[i].e_err}));
            check($sformatf("r%0d_summary", i),    32'(summ),            32'(vecs[i].e_sum));
            check($sformatf("r%0d_haltsum0", i),   haltsum0,             vecs[i].e_hs);
        end

        // Acknowledge havereset on hart 3, then collide an ack with a reset pulse.
        @(posedge clk); #1;
        idle_inputs();
        hasel = 1'b0; hartsel = 5'd3; ctl_write = 1'b1; ctl_ackhavereset = 1'b1;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check("ack_havereset3", 32'(allhavereset), 32'd0);
        @(posedge clk); #1;
        ctl_write = 1'b1; ctl_ackhavereset = 1'b1; hart_reset = 4'b1000;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check("havereset_set_wins", 32'(allhavereset), 32'd1);

        // Start a command on halted hart 1, then reset while it is executing.
        @(posedge clk); #1;
        hartsel = 5'd1; cmd_exec = 1'b1;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check("exec_start", 32'({cmd_busy, hart_exec}), 32'({1'b1, 4'b0010}));
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; hart_done = 4'b0010;
        @(negedge clk);
        check("reset_mid_exec", 32'({cmd_busy, hart_exec, cmderr}), 32'({1'b0, 4'b0000, 3'd0}));
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check("late_done_ignored", 32'({cmd_busy, cmderr}), 32'({1'b0, 3'd0}));
        check("reset_havereset", 32'(allhavereset), 32'd1);

        // dmactive low wipes a pending halt request.
        @(posedge clk); #1;
        hartsel = 5'd0; ctl_write = 1'b1; ctl_haltreq = 1'b1;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check("haltreq_hart0", 32'(hart_halt_req), 32'(4'b0001));
        @(posedge clk); #1;
        dmactive = 1'b0;
        @(posedge clk); #1;
        dmactive = 1'b1;
        @(negedge clk);
        check("dmactive_clear", 32'(hart_halt_req), 32'(4'b0000));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
